// File: rtl/delay_timer_monitor.sv
// -----------------------------------------------------------------------------
// delay_timer_monitor
//
// Purpose:
//   Watches the trigger line and the active-low output of a delay timer
//   (internal timer or an external LS7212). For each armed event it measures:
//     - the delay from the selected trigger edge to the delay_out_n falling edge
//     - the number of cycles delay_out_n stayed low
//   It returns both counts, plus a timeout flag, over a valid/ready handshake.
//
// Optional feature:
//   Define DELAY_MON_STATS_EN to add the running statistics outputs
//   stat_min, stat_max and stat_cnt. These update on every result transfer.
//
// Ports:
//   clk          system clock; all logic runs on its rising edge
//   reset_n      synchronous, active-low reset
//   trigger      asynchronous trigger line (2-FF synchronised)
//   delay_out_n  asynchronous timer output, active low (2-FF synchronised)
//   trig_edge    0 = measure from the rising trigger edge, 1 = from the falling edge
//   arm          single-cycle request to capture the next event
//   busy         high whenever the FSM is not idle
//   res_valid    a result is available
//   res_ready    the consumer accepts the result
//   res_delay    trigger edge to delay_out_n falling edge, in cycles
//   res_width    cycles delay_out_n was low
//   res_timeout  a measurement phase hit TIMEOUT
//   stat_min     (DELAY_MON_STATS_EN) min res_delay of non-timeout events
//   stat_max     (DELAY_MON_STATS_EN) max res_delay of non-timeout events
//   stat_cnt     (DELAY_MON_STATS_EN) saturating count of completed events
// -----------------------------------------------------------------------------
module delay_timer_monitor #(
    parameter int            CW      = 16,
    parameter logic [CW-1:0] TIMEOUT = CW'(16'hFFFF)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          trigger,
    input  logic          delay_out_n,
    input  logic          trig_edge,
    input  logic          arm,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_delay,
    output logic [CW-1:0] res_width,
    output logic          res_timeout
`ifdef DELAY_MON_STATS_EN
    ,
    output logic [CW-1:0] stat_min,
    output logic [CW-1:0] stat_max,
    output logic [CW-1:0] stat_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_ASSERT,
        MEASURE_WIDTH,
        REPORT
    } state_t;

    state_t        state_q, state_d;

    // Both lines go through identical three-stage chains: two stages of
    // synchronisation plus one "previous value" stage for edge detection.
    // Keeping the depths equal preserves the relative timing exactly.
    logic          trig_s1_q, trig_s1_d;
    logic          trig_s2_q, trig_s2_d;
    logic          trig_s3_q, trig_s3_d;
    logic          dly_s1_q, dly_s1_d;
    logic          dly_s2_q, dly_s2_d;
    logic          dly_s3_q, dly_s3_d;

    logic          edge_sel_q, edge_sel_d;
    logic [CW-1:0] delay_cnt_q, delay_cnt_d;
    logic [CW-1:0] width_cnt_q, width_cnt_d;
    logic [CW-1:0] res_delay_q, res_delay_d;
    logic [CW-1:0] res_width_q, res_width_d;
    logic          res_timeout_q, res_timeout_d;

`ifdef DELAY_MON_STATS_EN
    logic [CW-1:0] stat_min_q, stat_min_d;
    logic [CW-1:0] stat_max_q, stat_max_d;
    logic [CW-1:0] stat_cnt_q, stat_cnt_d;
`endif

    logic          trig_hit;
    logic          dly_fall;
    logic          dly_rise;

    // Edge detection on the second synchroniser stage against its previous value.
    assign trig_hit = edge_sel_q ? (~trig_s2_q & trig_s3_q) : (trig_s2_q & ~trig_s3_q);
    assign dly_fall = ~dly_s2_q & dly_s3_q;
    assign dly_rise = dly_s2_q & ~dly_s3_q;

    assign busy        = (state_q != IDLE);
    assign res_valid   = (state_q == REPORT);
    assign res_delay   = res_delay_q;
    assign res_width   = res_width_q;
    assign res_timeout = res_timeout_q;

`ifdef DELAY_MON_STATS_EN
    assign stat_min = stat_min_q;
    assign stat_max = stat_max_q;
    assign stat_cnt = stat_cnt_q;
`endif

    // Next-state and datapath logic. The delay counter holds (cycles since the
    // trigger edge - 1), so the captured delay is the counter plus one: the
    // cycle on which the falling edge is seen counts as cycle N. The width
    // counter starts at 1 on the falling-edge cycle, so on the rising-edge
    // cycle it already equals the number of low cycles.
    always_comb begin
        state_d       = state_q;
        trig_s1_d     = trigger;
        trig_s2_d     = trig_s1_q;
        trig_s3_d     = trig_s2_q;
        dly_s1_d      = delay_out_n;
        dly_s2_d      = dly_s1_q;
        dly_s3_d      = dly_s2_q;
        edge_sel_d    = edge_sel_q;
        delay_cnt_d   = delay_cnt_q;
        width_cnt_d   = width_cnt_q;
        res_delay_d   = res_delay_q;
        res_width_d   = res_width_q;
        res_timeout_d = res_timeout_q;
`ifdef DELAY_MON_STATS_EN
        stat_min_d    = stat_min_q;
        stat_max_d    = stat_max_q;
        stat_cnt_d    = stat_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (arm) begin
                    edge_sel_d = trig_edge;
                    state_d    = ARMED;
                end
            end

            ARMED: begin
                if (trig_hit) begin
                    if (!dly_s2_q) begin
                        // Output already asserted when the trigger edge arrives.
                        res_delay_d = '0;
                        width_cnt_d = CW'(1);
                        state_d     = MEASURE_WIDTH;
                    end else begin
                        delay_cnt_d = '0;
                        state_d     = WAIT_ASSERT;
                    end
                end
            end

            WAIT_ASSERT: begin
                if (dly_fall) begin
                    res_delay_d = delay_cnt_q + CW'(1);
                    width_cnt_d = CW'(1);
                    state_d     = MEASURE_WIDTH;
                end else if (delay_cnt_q + CW'(1) == TIMEOUT) begin
                    res_delay_d   = TIMEOUT;
                    res_width_d   = '0;
                    res_timeout_d = 1'b1;
                    state_d       = REPORT;
                end else begin
                    delay_cnt_d = delay_cnt_q + CW'(1);
                end
            end

            MEASURE_WIDTH: begin
                if (dly_rise) begin
                    res_width_d   = width_cnt_q;
                    res_timeout_d = 1'b0;
                    state_d       = REPORT;
                end else if (width_cnt_q == TIMEOUT) begin
                    res_width_d   = TIMEOUT;
                    res_timeout_d = 1'b1;
                    state_d       = REPORT;
                end else if (!dly_s2_q) begin
                    width_cnt_d = width_cnt_q + CW'(1);
                end
            end

            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
`ifdef DELAY_MON_STATS_EN
                    if (stat_cnt_q != '1) begin
                        stat_cnt_d = stat_cnt_q + CW'(1);
                    end
                    if (!res_timeout_q) begin
                        if (res_delay_q < stat_min_q) begin
                            stat_min_d = res_delay_q;
                        end
                        if (res_delay_q > stat_max_q) begin
                            stat_max_d = res_delay_q;
                        end
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Synchronisers reset to the inactive
    // level of each line so no spurious edge is seen after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            trig_s1_q     <= 1'b0;
            trig_s2_q     <= 1'b0;
            trig_s3_q     <= 1'b0;
            dly_s1_q      <= 1'b1;
            dly_s2_q      <= 1'b1;
            dly_s3_q      <= 1'b1;
            edge_sel_q    <= 1'b0;
            delay_cnt_q   <= '0;
            width_cnt_q   <= '0;
            res_delay_q   <= '0;
            res_width_q   <= '0;
            res_timeout_q <= 1'b0;
`ifdef DELAY_MON_STATS_EN
            stat_min_q    <= '1;
            stat_max_q    <= '0;
            stat_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            trig_s1_q     <= trig_s1_d;
            trig_s2_q     <= trig_s2_d;
            trig_s3_q     <= trig_s3_d;
            dly_s1_q      <= dly_s1_d;
            dly_s2_q      <= dly_s2_d;
            dly_s3_q      <= dly_s3_d;
            edge_sel_q    <= edge_sel_d;
            delay_cnt_q   <= delay_cnt_d;
            width_cnt_q   <= width_cnt_d;
            res_delay_q   <= res_delay_d;
            res_width_q   <= res_width_d;
            res_timeout_q <= res_timeout_d;
`ifdef DELAY_MON_STATS_EN
            stat_min_q    <= stat_min_d;
            stat_max_q    <= stat_max_d;
            stat_cnt_q    <= stat_cnt_d;
`endif
        end
    end

endmodule
